// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter: decodes entry/exit at two gates and arbitrates them onto one inc/dec counter interface
module parking_gate_arbiter #(
    parameter int CAPACITY = 25,
    parameter int CNT_W    = 5,
    parameter int PEND_W   = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             a0_i,
    input  logic             b0_i,
    input  logic             a1_i,
    input  logic             b1_i,
    output logic             inc_o,
    output logic             dec_o,
    output logic [CNT_W-1:0] occupancy_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [1:0]       err_o,
    output logic [1:0]       drop_o,
    output logic             uflow_o
);
    typedef enum logic [2:0] {IDLE, EN1, EN2, EN3, EX1, EX2, EX3, ERR} state_t;

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [CNT_W-1:0]  CAP      = CNT_W'(CAPACITY);

    logic [1:0]        sync1_q    [2];
    logic [1:0]        ab_q       [2];
    state_t            state_q    [2];
    state_t            state_d    [2];
    logic [PEND_W-1:0] pend_in_q  [2];
    logic [PEND_W-1:0] pend_in_d  [2];
    logic [PEND_W-1:0] pend_out_q [2];
    logic [PEND_W-1:0] pend_out_d [2];
    logic [1:0]        ent_ev, ext_ev, err_d, drop_d;
    logic [1:0]        has_in, has_out, ret_in, ret_out;
    logic              sel_in, sel_out, srv_in, srv_out;
    logic              last_in_q, last_out_q;
    logic [CNT_W-1:0]  occ_q, occ_d;
    logic              inc_q, dec_q, uflow_q, inc_d, dec_d, uflow_d;
    logic [1:0]        err_q, drop_q;

    // two-flop synchronizer per gate, {a,b} packed, cleared in reset
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            sync1_q <= '{default: 2'b00};
            ab_q    <= '{default: 2'b00};
        end else begin
            sync1_q[0] <= {a0_i, b0_i};
            sync1_q[1] <= {a1_i, b1_i};
            ab_q       <= sync1_q;
        end
    end

    // sensor FSM state register
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 2; i++) begin
            state_q[i] <= !reset_i ? IDLE : state_d[i];
        end
    end

    // sensor sequence decode: next state, completed events, error entry
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                IDLE:    state_d[i] = (ab_q[i] == 2'b10) ? EN1 : (ab_q[i] == 2'b01) ? EX1 :
                                      (ab_q[i] == 2'b11) ? ERR : IDLE;
                EN1:     state_d[i] = (ab_q[i] == 2'b11) ? EN2 : (ab_q[i] == 2'b00) ? IDLE :
                                      (ab_q[i] == 2'b01) ? ERR : EN1;
                EN2:     state_d[i] = (ab_q[i] == 2'b01) ? EN3 : (ab_q[i] == 2'b10) ? EN1 :
                                      (ab_q[i] == 2'b00) ? ERR : EN2;
                EN3:     state_d[i] = (ab_q[i] == 2'b00) ? IDLE : (ab_q[i] == 2'b11) ? EN2 :
                                      (ab_q[i] == 2'b10) ? ERR : EN3;
                EX1:     state_d[i] = (ab_q[i] == 2'b11) ? EX2 : (ab_q[i] == 2'b00) ? IDLE :
                                      (ab_q[i] == 2'b10) ? ERR : EX1;
                EX2:     state_d[i] = (ab_q[i] == 2'b10) ? EX3 : (ab_q[i] == 2'b01) ? EX1 :
                                      (ab_q[i] == 2'b00) ? ERR : EX2;
                EX3:     state_d[i] = (ab_q[i] == 2'b00) ? IDLE : (ab_q[i] == 2'b11) ? EX2 :
                                      (ab_q[i] == 2'b01) ? ERR : EX3;
                ERR:     state_d[i] = (ab_q[i] == 2'b00) ? IDLE : ERR;
                default: state_d[i] = IDLE;
            endcase
            ent_ev[i] = (state_q[i] == EN3) && (ab_q[i] == 2'b00);
            ext_ev[i] = (state_q[i] == EX3) && (ab_q[i] == 2'b00);
            err_d[i]  = (state_d[i] == ERR) && (state_q[i] != ERR);
        end
    end

    // exits always win; within a class the gate served last loses a tie
    assign has_out = {pend_out_q[1] != '0, pend_out_q[0] != '0};
    assign has_in  = {pend_in_q[1] != '0, pend_in_q[0] != '0};
    assign sel_out = (&has_out) ? ~last_out_q : has_out[1];
    assign sel_in  = (&has_in) ? ~last_in_q : has_in[1];
    assign srv_out = |has_out;
    assign srv_in  = ~srv_out & (|has_in) & ~full_o;
    assign dec_d   = srv_out & (occ_q != '0);
    assign uflow_d = srv_out & (occ_q == '0);
    assign inc_d   = srv_in;
    assign ret_out = {srv_out & sel_out, srv_out & ~sel_out};
    assign ret_in  = {srv_in & sel_in, srv_in & ~sel_in};
    assign occ_d   = dec_d ? occ_q - 1'b1 : inc_d ? occ_q + 1'b1 : occ_q;

    // pending counters: an event and a retire on the same counter cancel, a saturated event is dropped
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            pend_in_d[i]  = (ent_ev[i] & ~ret_in[i] & (pend_in_q[i] != PEND_MAX)) ? pend_in_q[i] + 1'b1 :
                            (~ent_ev[i] & ret_in[i]) ? pend_in_q[i] - 1'b1 : pend_in_q[i];
            pend_out_d[i] = (ext_ev[i] & ~ret_out[i] & (pend_out_q[i] != PEND_MAX)) ? pend_out_q[i] + 1'b1 :
                            (~ext_ev[i] & ret_out[i]) ? pend_out_q[i] - 1'b1 : pend_out_q[i];
            drop_d[i]     = (ent_ev[i] & ~ret_in[i] & (pend_in_q[i] == PEND_MAX)) |
                            (ext_ev[i] & ~ret_out[i] & (pend_out_q[i] == PEND_MAX));
        end
    end

    // pending queues, round-robin pointers, shadow occupancy and registered pulses
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            pend_in_q  <= '{default: '0};
            pend_out_q <= '{default: '0};
            last_in_q  <= 1'b1;
            last_out_q <= 1'b1;
            occ_q      <= '0;
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
            uflow_q    <= 1'b0;
            err_q      <= '0;
            drop_q     <= '0;
        end else begin
            pend_in_q  <= pend_in_d;
            pend_out_q <= pend_out_d;
            last_in_q  <= srv_in ? sel_in : last_in_q;
            last_out_q <= srv_out ? sel_out : last_out_q;
            occ_q      <= occ_d;
            inc_q      <= inc_d;
            dec_q      <= dec_d;
            uflow_q    <= uflow_d;
            err_q      <= err_d;
            drop_q     <= drop_d;
        end
    end

    assign inc_o       = inc_q;
    assign dec_o       = dec_q;
    assign uflow_o     = uflow_q;
    assign err_o       = err_q;
    assign drop_o      = drop_q;
    assign occupancy_o = occ_q;
    assign full_o      = occ_q == CAP;
    assign empty_o     = occ_q == '0;
endmodule

// File: tb/tb_parking_gate_arbiter.sv
// tb_parking_gate_arbiter: directed and randomized checks against a path-walking occupancy model
module tb_parking_gate_arbiter;
    localparam int CAP  = 25;
    localparam int PMAX = 3;
    localparam logic [7:0] ENTRY   = 8'b10_11_01_00;
    localparam logic [7:0] EXIT    = 8'b01_11_10_00;
    localparam logic [7:0] BACKOUT = 8'b10_11_10_00;

    logic       clk = 1'b0, reset = 1'b0;
    logic       a0 = 1'b0, b0 = 1'b0, a1 = 1'b0, b1 = 1'b0;
    logic       inc, dec, full, empty, uflow;
    logic [4:0] occ;
    logic [1:0] err, drop;
    int         tests = 0, fails = 0;

    always #5 clk = ~clk;

    parking_gate_arbiter dut (
        .clk_i(clk), .reset_i(reset),
        .a0_i(a0), .b0_i(b0), .a1_i(a1), .b1_i(b1),
        .inc_o(inc), .dec_o(dec), .occupancy_o(occ),
        .full_o(full), .empty_o(empty),
        .err_o(err), .drop_o(drop), .uflow_o(uflow)
    );

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            if (fails <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // position p along the entry path 00,10,11,01 (d=1) or the exit path 00,01,11,10 (d=2)
    function automatic logic [1:0] path(input int d, input int p);
        logic [1:0] v;
        v = (p == 1) ? 2'b10 : (p == 2) ? 2'b11 : (p == 3) ? 2'b01 : 2'b00;
        return (d == 2) ? {v[0], v[1]} : v;
    endfunction

    // reference model: dir 0 idle, 1 walking entry, 2 walking exit, 3 error
    logic [1:0] m_s1 [2];
    logic [1:0] m_s2 [2];
    int         m_dir [2], m_pos [2], m_pin [2], m_pout [2];
    int         m_occ = 0, m_last_in = 1, m_last_out = 1;
    logic       e_inc = 0, e_dec = 0, e_uflow = 0;
    logic [1:0] e_err = 0, e_drop = 0;
    bit         chk_en = 0;

    initial begin
        int rin, rout, ev;
        logic [1:0] v;
        forever begin
            @(posedge clk);
            if (!reset) begin
                for (int i = 0; i < 2; i++) begin
                    m_s1[i] = 0; m_s2[i] = 0; m_dir[i] = 0; m_pos[i] = 0; m_pin[i] = 0; m_pout[i] = 0;
                end
                m_occ = 0; m_last_in = 1; m_last_out = 1;
                e_inc = 0; e_dec = 0; e_uflow = 0; e_err = 0; e_drop = 0;
                chk_en = 1;
            end else begin
                e_inc = 0; e_dec = 0; e_uflow = 0; e_err = 0; e_drop = 0;
                if (m_pout[0] > 0 || m_pout[1] > 0) begin
                    rout = (m_pout[0] > 0 && m_pout[1] > 0) ? 1 - m_last_out : (m_pout[0] > 0 ? 0 : 1);
                    m_last_out = rout;
                    m_pout[rout]--;
                    if (m_occ > 0) begin e_dec = 1; m_occ--; end
                    else e_uflow = 1;
                end else if ((m_pin[0] > 0 || m_pin[1] > 0) && m_occ < CAP) begin
                    rin = (m_pin[0] > 0 && m_pin[1] > 0) ? 1 - m_last_in : (m_pin[0] > 0 ? 0 : 1);
                    m_last_in = rin;
                    m_pin[rin]--;
                    e_inc = 1;
                    m_occ++;
                end
                for (int i = 0; i < 2; i++) begin
                    v = m_s2[i];
                    ev = 0;
                    if (m_dir[i] == 3) begin
                        if (v == 2'b00) m_dir[i] = 0;
                    end else if (m_dir[i] == 0) begin
                        if (v == 2'b11) begin m_dir[i] = 3; e_err[i] = 1; end
                        else if (v != 2'b00) begin m_dir[i] = (v == 2'b10) ? 1 : 2; m_pos[i] = 1; end
                    end else if (v != path(m_dir[i], m_pos[i])) begin
                        if (v == path(m_dir[i], (m_pos[i] + 1) % 4)) begin
                            if (m_pos[i] == 3) begin ev = m_dir[i]; m_dir[i] = 0; m_pos[i] = 0; end
                            else m_pos[i]++;
                        end else if (v == path(m_dir[i], m_pos[i] - 1)) begin
                            m_pos[i]--;
                            if (m_pos[i] == 0) m_dir[i] = 0;
                        end else begin
                            m_dir[i] = 3; m_pos[i] = 0; e_err[i] = 1;
                        end
                    end
                    if (ev == 1) begin if (m_pin[i] == PMAX) e_drop[i] = 1; else m_pin[i]++; end
                    if (ev == 2) begin if (m_pout[i] == PMAX) e_drop[i] = 1; else m_pout[i]++; end
                    m_s2[i] = m_s1[i];
                end
                m_s1[0] = {a0, b0};
                m_s1[1] = {a1, b1};
            end
        end
    end

    // every-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("inc", int'(inc), int'(e_inc));
            chk("dec", int'(dec), int'(e_dec));
            chk("uflow", int'(uflow), int'(e_uflow));
            chk("err", int'(err), int'(e_err));
            chk("drop", int'(drop), int'(e_drop));
            chk("occupancy", int'(occ), m_occ);
            chk("full", int'(full), int'(m_occ == CAP));
            chk("empty", int'(empty), int'(m_occ == 0));
        end
    end

    // pulse counters and timestamps used by the directed checks
    int cyc = 0, n_inc = 0, n_dec = 0, n_uflow = 0, n_err = 0, n_err1 = 0, n_drop = 0;
    int t_inc = 0, t_inc_prev = 0, t_dec = 0;
    initial forever begin
        @(negedge clk);
        cyc++;
        if (inc) begin t_inc_prev = t_inc; t_inc = cyc; n_inc++; end
        if (dec) begin t_dec = cyc; n_dec++; end
        if (uflow) n_uflow++;
        if (|err) n_err++;
        if (err[1]) n_err1++;
        if (|drop) n_drop++;
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic drive(input int g, input logic [1:0] v);
        if (g == 0) {a0, b0} = v;
        else {a1, b1} = v;
    endtask

    task automatic run(input logic [1:0] m, input logic [7:0] s);
        for (int k = 3; k >= 0; k--) begin
            if (m[0]) drive(0, s[2*k +: 2]);
            if (m[1]) drive(1, s[2*k +: 2]);
            wait_n(3);
        end
        wait_n(6);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bi, bd, be, be1, bu, bdr;
        int gp [2], gd [2], gh [2], r;
        wait_n(3);
        reset = 1'b1;
        wait_n(2);
        chk("reset_occ", int'(occ), 0);
        chk("reset_empty", int'(empty), 1);
        chk("reset_full", int'(full), 0);
        chk("reset_inc", int'(inc), 0);

        bi = n_inc; be = n_err;
        drive(0, 2'b10); wait_n(3);
        drive(0, 2'b11); wait_n(3);
        drive(0, 2'b01); wait_n(3);
        drive(0, 2'b00); wait_n(3);
        chk("latency_edge3", int'(inc), 0);
        wait_n(1);
        chk("latency_edge4", int'(inc), 1);
        wait_n(6);
        chk("entry_inc_count", n_inc - bi, 1);
        chk("entry_occ", int'(occ), 1);
        chk("entry_err", n_err - be, 0);

        bi = n_inc; bd = n_dec; be = n_err;
        run(2'b01, BACKOUT);
        chk("backout_inc", n_inc - bi, 0);
        chk("backout_dec", n_dec - bd, 0);
        chk("backout_err", n_err - be, 0);
        chk("backout_occ", int'(occ), 1);

        bi = n_inc; be1 = n_err1;
        drive(1, 2'b11); wait_n(4);
        drive(1, 2'b10); wait_n(3);
        drive(1, 2'b11); wait_n(3);
        drive(1, 2'b01); wait_n(3);
        drive(1, 2'b00); wait_n(6);
        chk("err1_pulses", n_err1 - be1, 1);
        chk("err_hold_no_inc", n_inc - bi, 0);
        run(2'b10, ENTRY);
        chk("after_err_inc", n_inc - bi, 1);
        chk("after_err_occ", int'(occ), 2);

        bi = n_inc;
        run(2'b11, ENTRY);
        chk("both_inc_count", n_inc - bi, 2);
        chk("both_consecutive", t_inc - t_inc_prev, 1);
        chk("both_occ", int'(occ), 4);

        for (int k = 0; k < 21; k++) run(2'b01, ENTRY);
        chk("fill_occ", int'(occ), 25);
        chk("fill_full", int'(full), 1);
        bi = n_inc; bdr = n_drop;
        run(2'b01, ENTRY);
        chk("full_no_inc", n_inc - bi, 0);
        chk("full_no_drop", n_drop - bdr, 0);
        chk("full_stays", int'(full), 1);
        bd = n_dec;
        run(2'b10, EXIT);
        chk("full_exit_dec", n_dec - bd, 1);
        chk("full_held_inc", n_inc - bi, 1);
        chk("dec_then_inc", t_inc - t_dec, 1);
        chk("full_exit_occ", int'(occ), 25);

        be = n_err; bi = n_inc;
        drive(0, 2'b10); wait_n(3);
        drive(0, 2'b11); wait_n(3);
        reset = 1'b0;
        wait_n(2);
        drive(0, 2'b00);
        wait_n(3);
        reset = 1'b1;
        wait_n(6);
        chk("midreset_occ", int'(occ), 0);
        chk("midreset_empty", int'(empty), 1);
        chk("midreset_full", int'(full), 0);
        chk("midreset_err", n_err - be, 0);
        chk("midreset_inc", n_inc - bi, 0);
        run(2'b01, ENTRY);
        chk("post_reset_entry", int'(occ), 1);
        run(2'b01, EXIT);
        chk("post_reset_exit", int'(occ), 0);

        bu = n_uflow; bd = n_dec;
        run(2'b01, EXIT);
        chk("uflow_pulse", n_uflow - bu, 1);
        chk("uflow_no_dec", n_dec - bd, 0);
        chk("uflow_occ", int'(occ), 0);

        for (int g = 0; g < 2; g++) begin gp[g] = 0; gd[g] = 1; gh[g] = 0; end
        for (int c = 0; c < 3000; c++) begin
            for (int g = 0; g < 2; g++) begin
                if (gh[g] > 0) gh[g]--;
                else begin
                    r = int'($urandom_range(99));
                    if (gp[g] == 0) gd[g] = ($urandom_range(99) < 56) ? 1 : 2;
                    if (r < 80) gp[g] = (gp[g] + 1) % 4;
                    else if (r < 90 && gp[g] > 0) gp[g]--;
                    drive(g, (r >= 90) ? 2'($urandom_range(3)) : path(gd[g], gp[g]));
                    gh[g] = int'($urandom_range(2));
                end
            end
            wait_n(1);
        end
        drive(0, 2'b00);
        drive(1, 2'b00);
        wait_n(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
